// File: rtl/wb_burst_master.sv
// Wishbone B3 master: one command becomes a single or incrementing-burst bus cycle.
// Latency: cyc rises the cycle after cmd accept; rd_valid is one cycle after each read ack.
// Backpressure: cmd_ready only in IDLE; wr_ready while the one-beat staging slot is free or draining.
module wb_burst_master #(
    parameter int DW    = 32,
    parameter int AW    = 26,
    parameter int LEN_W = 8,
    parameter int TMO_W = 10
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);
    localparam int SW = DW / 8;
    localparam logic [AW-1:0]    STEP     = AW'(SW);
    localparam logic [AW-1:0]    ALIGN    = ~AW'(SW - 1);
    // The stall that would take the counter to all-ones is the one that fires the timeout.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic               we_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic [LEN_W:0]     load_q;
    logic [SW-1:0]      sel_q;
    logic [AW-1:0]      addr_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               tmo_err_q;
    logic               stg_full_q;
    logic [DW-1:0]      stg_q;
    logic               rdy_q;
    logic               rd_vld_q;
    logic [DW-1:0]      rd_dat_q;

    logic cmd_fire, wr_fire, stb, beat_done, last_beat, tmo_hit;

    assign cmd_fire  = cmd_valid && rdy_q;
    assign stb       = (state_q == RUN) && (!we_q || stg_full_q);
    assign beat_done = stb && wb_ack_i;
    assign last_beat = (beat_q == len_q);
    assign tmo_hit   = stb && !wb_ack_i && (tmo_q == TMO_LAST);
    // Stop taking write data once every beat of the command has been staged.
    assign wr_ready  = (state_q == RUN) && we_q && (load_q <= {1'b0, len_q}) &&
                       (!stg_full_q || beat_done);
    assign wr_fire   = wr_valid && wr_ready;

    assign cmd_ready = rdy_q;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = stg_q;
    assign rd_valid  = rd_vld_q;
    assign rd_data   = rd_dat_q;

    // State register; cmd_ready is registered so it reads 0 throughout reset.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
        end
    end

    // Next-state: last ack or timeout ends the cycle, FIN lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = RUN;
            RUN:     if ((beat_done && last_beat) || tmo_hit) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        wb_cyc_o = (state_q == RUN);
        wb_stb_o = stb;
        wb_we_o  = (state_q == RUN) && we_q;
        wb_sel_o = (state_q == RUN) ? sel_q : '0;
        wb_cti_o = 3'b000;
        if (state_q == RUN && len_q != '0)
            wb_cti_o = last_beat ? 3'b111 : 3'b010;
        done = (state_q == FIN);
        err  = (state_q == FIN) && tmo_err_q;
    end

    // Command latch, address/beat stepping and the ack timeout counter.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            we_q      <= 1'b0;
            len_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            beat_q    <= '0;
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else if (cmd_fire) begin
            we_q      <= cmd_we;
            len_q     <= cmd_len;
            sel_q     <= cmd_sel;
            addr_q    <= cmd_addr & ALIGN;
            beat_q    <= '0;
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (beat_done) begin
                addr_q <= addr_q + STEP;
                beat_q <= beat_q + 1'b1;
                tmo_q  <= '0;
            end else if (stb) begin
                tmo_q  <= tmo_q + 1'b1;
            end
            if (tmo_hit) tmo_err_q <= 1'b1;
        end
    end

    // One-beat write staging slot; a refill and a drain in the same cycle keep it full.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            stg_full_q <= 1'b0;
            stg_q      <= '0;
            load_q     <= '0;
        end else begin
            if (cmd_fire) load_q <= '0;
            else if (wr_fire) load_q <= load_q + 1'b1;
            if (wr_fire) begin
                stg_full_q <= 1'b1;
                stg_q      <= wr_data;
            end else if ((beat_done && we_q) || state_q != RUN) begin
                stg_full_q <= 1'b0;
            end
        end
    end

    // Read beats are registered out one cycle after their ack.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= beat_done && !we_q;
            if (beat_done && !we_q) rd_dat_q <= wb_dat_i;
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: slave model with wait states, write-data source, scoreboards.
// Latency: every comparison is sampled 1 time unit after the falling clock edge.
// Backpressure: write source honours wr_ready and can insert programmable gaps.
module tb_wb_burst_master;
    logic        sys_clk = 1'b0;
    logic        RESETN;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [25:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done, err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    wb_burst_master #(.DW(32), .AW(26), .LEN_W(8), .TMO_W(4)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [25:0] addr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_beat[$];
    logic [31:0] exp_rd[$];
    logic [31:0] wr_src[$];

    int total = 0, bad = 0;
    int cyc_n = 0, done_cnt = 0, err_cnt = 0, stb_hi = 0, gap_cyc = 0;
    int acks = 0, first_ack = -1, last_ack = -1, done_cyc = -1, accept_cyc = -1;
    int wait_n = 0, wcnt = 0, wr_gap = 0, gap_left = 0;
    bit never = 0;
    logic [31:0] slv_xor = 32'h0;

    // One clock: handshakes, source update, slave response, scoreboard.
    task automatic tick();
        bit w_took, c_took;
        beat_t e;
        logic [31:0] r;
        w_took = wr_valid && wr_ready;
        c_took = cmd_valid && cmd_ready;
        if (c_took) accept_cyc = cyc_n;
        @(posedge sys_clk);
        #1;
        cyc_n++;
        if (c_took) cmd_valid = 1'b0;
        if (w_took) begin
            void'(wr_src.pop_front());
            gap_left = wr_gap;
        end
        if (gap_left > 0) begin
            wr_valid = 1'b0;
            gap_left--;
        end else if (wr_src.size() > 0) begin
            wr_valid = 1'b1;
            wr_data  = wr_src[0];
        end else begin
            wr_valid = 1'b0;
        end
        @(negedge sys_clk);
        wb_ack_i = wb_stb_o && !never && (wcnt == wait_n);
        wb_dat_i = {6'b0, wb_addr_o} ^ slv_xor;
        #1;
        if (wb_stb_o) begin
            stb_hi++;
            if (wb_ack_i) wcnt = 0;
            else wcnt++;
        end
        if (wb_cyc_o && !wb_stb_o) gap_cyc++;
        if (wb_stb_o && wb_ack_i) begin
            acks++;
            if (first_ack < 0) first_ack = cyc_n;
            last_ack = cyc_n;
            total++;
            if (exp_beat.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: addr=%h cti=%b", wb_addr_o, wb_cti_o);
            end else begin
                e = exp_beat.pop_front();
                if ({wb_addr_o, wb_cti_o, wb_we_o, wb_sel_o} !== {e.addr, e.cti, e.we, e.sel}) begin
                    bad++;
                    $display("FAIL beat_ctl: got addr=%h cti=%b we=%b sel=%h want addr=%h cti=%b we=%b sel=%h",
                             wb_addr_o, wb_cti_o, wb_we_o, wb_sel_o, e.addr, e.cti, e.we, e.sel);
                end
                if (e.we) begin
                    total++;
                    if (wb_dat_o !== e.dat) begin
                        bad++;
                        $display("FAIL beat_wdat: got %h want %h", wb_dat_o, e.dat);
                    end
                end
            end
        end
        if (rd_valid) begin
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %h", rd_data);
            end else begin
                r = exp_rd.pop_front();
                if (rd_data !== r) begin
                    bad++;
                    $display("FAIL rd_data: got %h want %h", rd_data, r);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (err) err_cnt++;
    endtask

    // Queue the expected beats (and read data / write source) for one command.
    task automatic push_cmd(input bit we, input logic [25:0] a, input int len,
                            input logic [3:0] sel, input logic [31:0] d0);
        beat_t e;
        for (int i = 0; i <= len; i++) begin
            e.addr = a + 26'(4 * i);
            e.cti  = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
            e.we   = we;
            e.sel  = sel;
            e.dat  = we ? d0 + 32'(i) : 32'h0;
            exp_beat.push_back(e);
            if (we) wr_src.push_back(d0 + 32'(i));
            else exp_rd.push_back({6'b0, e.addr} ^ slv_xor);
        end
    endtask

    task automatic send_cmd(input bit we, input logic [25:0] a, input int len, input logic [3:0] sel);
        cmd_we = we; cmd_addr = a; cmd_len = 8'(len); cmd_sel = sel; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && cmd_valid; i++) tick();
        total++;
        if (cmd_valid) begin
            bad++;
            cmd_valid = 1'b0;
            $display("FAIL cmd_accept: cmd_ready never seen, want accept within 50 cycles");
        end
    endtask

    task automatic wait_done(input int bound);
        int d0 = done_cnt;
        for (int i = 0; i < bound && done_cnt == d0; i++) tick();
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end else if (wb_cyc_o !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle: cyc=%b cmd_ready=%b want 0 0", wb_cyc_o, cmd_ready);
        end
        total++;
        if (exp_beat.size() != 0 || exp_rd.size() != 0) begin
            bad++;
            $display("FAIL sb_left: beats=%0d rd=%0d want 0 0", exp_beat.size(), exp_rd.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({cmd_ready, wr_ready, rd_valid, rd_data, done, err, wb_cyc_o, wb_stb_o, wb_we_o,
             wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== '0) begin
            bad++;
            $display("FAIL %s: outputs cyc=%b stb=%b addr=%h dat=%h rdv=%b done=%b cmd_rdy=%b want all 0",
                     name, wb_cyc_o, wb_stb_o, wb_addr_o, wb_dat_o, rd_valid, done, cmd_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        #1;
        check_all_zero("reset_outputs");
        RESETN = 1'b1;
        tick();
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_read();
        int e0 = err_cnt;
        wait_n = 1; wcnt = 0; slv_xor = 32'hDEADBEEF ^ 32'h100;
        push_cmd(0, 26'h100, 0, 4'hF, 0);
        send_cmd(0, 26'h100, 0, 4'hF);
        wait_done(40);
        total++;
        if (err_cnt != e0) begin
            bad++;
            $display("FAIL single_read_err: err pulses=%0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_write_burst();
        wait_n = 0; wcnt = 0; wr_gap = 0; acks = 0; first_ack = -1;
        push_cmd(1, 26'h200, 3, 4'hF, 32'd1);
        send_cmd(1, 26'h200, 3, 4'hF);
        wait_done(40);
        total++;
        if (acks != 4 || last_ack - first_ack != 3) begin
            bad++;
            $display("FAIL wr_b2b: acks=%0d span=%0d want 4 and 3", acks, last_ack - first_ack);
        end
    endtask

    task automatic test_write_gaps(input int gap, input int len, input logic [3:0] sel);
        int e0 = err_cnt;
        wait_n = 0; wcnt = 0; wr_gap = gap; gap_cyc = 0;
        push_cmd(1, 26'h0400, len, sel, 32'hA000_0000);
        send_cmd(1, 26'h0400, len, sel);
        wait_done(200);
        wr_gap = 0;
        total++;
        if (gap_cyc < gap * len || err_cnt != e0) begin
            bad++;
            $display("FAIL wr_gaps: stb-low cycles=%0d err=%0d want >=%0d and 0",
                     gap_cyc, err_cnt - e0, gap * len);
        end
    endtask

    task automatic test_addr_wrap();
        wait_n = 0; wcnt = 0; slv_xor = 32'h1234_5678;
        push_cmd(0, 26'h3FFFFF8, 3, 4'hF, 0);
        send_cmd(0, 26'h3FFFFF8, 3, 4'hF);
        wait_done(40);
    endtask

    task automatic test_timeout();
        int d0 = done_cnt, e0 = err_cnt;
        never = 1; wcnt = 0; stb_hi = 0;
        send_cmd(0, 26'h40, 3, 4'hF);
        wait_done(100);
        repeat (3) tick();
        never = 0; wcnt = 0;
        total++;
        if (stb_hi != 15) begin
            bad++;
            $display("FAIL tmo_stall: stb high cycles=%0d want 15", stb_hi);
        end
        total++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL tmo_pulse: done=%0d err=%0d want 1 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        int a0, d0;
        wait_n = 2; wcnt = 0; slv_xor = 32'h0F0F_0000;
        push_cmd(0, 26'h300, 3, 4'hF, 0);
        a0 = acks;
        send_cmd(0, 26'h300, 3, 4'hF);
        for (int i = 0; i < 50 && acks == a0; i++) tick();
        tick();
        RESETN = 1'b0;
        #1;
        check_all_zero("reset_mid_outputs");
        d0 = done_cnt;
        repeat (3) tick();
        total++;
        if (done_cnt != d0 || exp_rd.size() != 3) begin
            bad++;
            $display("FAIL reset_mid_lost: done=%0d pending_rd=%0d want 0 and 3", done_cnt - d0, exp_rd.size());
        end
        exp_beat.delete(); exp_rd.delete(); wr_src.delete();
        wcnt = 0;
        RESETN = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        wait_n = 0; wcnt = 0; slv_xor = 32'h5555_AAAA;
        push_cmd(0, 26'h500, 1, 4'hF, 0);
        send_cmd(0, 26'h500, 1, 4'hF);
        wait_done(40);
        push_cmd(0, 26'h600, 1, 4'hF, 0);
        send_cmd(0, 26'h600, 1, 4'hF);
        total++;
        if (accept_cyc - done_cyc != 1) begin
            bad++;
            $display("FAIL b2b_idle: accept-done=%0d want 1", accept_cyc - done_cyc);
        end
        wait_done(40);
    endtask

    initial begin
        RESETN = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_sel = '0; wr_valid = 1'b0; wr_data = '0; wb_ack_i = 1'b0; wb_dat_i = '0;
        test_reset();
        test_single_read();
        test_write_burst();
        test_write_gaps(2, 3, 4'hF);
        test_write_gaps(18, 1, 4'h5);
        test_write_gaps(0, 0, 4'hA);
        test_addr_wrap();
        test_timeout();
        test_reset_mid();
        test_single_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
